// File: rtl/platform_led_pkg.sv
// Shared constants for the platform LED controller: register word
// addresses and STATUS register bit positions.
package platform_led_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_SET          = 3'd1;
  localparam logic [2:0] ADDR_CLEAR        = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE       = 3'd3;
  localparam logic [2:0] ADDR_BLINK_EN     = 3'd4;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_PWM_DUTY     = 3'd6;
  localparam logic [2:0] ADDR_STATUS       = 3'd7;

  localparam int STATUS_BLINK_PHASE = 0;
  localparam int STATUS_PWM_ON      = 1;

endpackage

// File: rtl/platform_led_blink_timer.sv
// Blink time base: a free-running prescaler producing a one-cycle tick,
// and a blink counter that flips blink_phase every 'period' ticks.
// A period write restarts the half-period with the phase on.
module platform_led_blink_timer #(
  parameter int PRESCALE = 50000,
  parameter int PER_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PER_W-1:0] period,
  input  logic             period_wr,
  output logic             blink_phase,
  output logic             tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_cnt;
  logic [PER_W-1:0] blink_cnt;

  assign tick = (ps_cnt == PS_LAST);

  // Prescaler: 0..PRESCALE-1, untouched by register writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // Blink counter and phase; a period write takes priority over a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_wr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick && (period != '0)) begin
      if (blink_cnt == period - PER_W'(1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/platform_led_ctrl.sv
// Avalon-MM LED controller: DATA register with atomic set/clear/toggle,
// per-channel blink enable, programmable blink period and global PWM
// brightness, driving a registered LED output.
//
// Bus handshake: a write is accepted on the clk edge where chipselect=1
// and write_n=0; there is no backpressure (zero wait states). readdata is
// a pure combinational function of address and is valid every cycle,
// independent of chipselect.
module platform_led_ctrl
  import platform_led_pkg::*;
#(
  parameter int              WIDTH       = 10,
  parameter int              PRESCALE    = 50000,
  parameter int              PER_W       = 16,
  parameter int              PWM_W       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PWM_W:0] DUTY_FULL    = {1'b1, {PWM_W{1'b0}}};
  localparam logic [31:0]    DUTY_FULL_32 = 32'(DUTY_FULL);

  logic             wr_en;
  logic [WIDTH-1:0] wd_w;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] blink_en_q;
  logic [PER_W-1:0] period_q;
  logic [PWM_W:0]   duty_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;
  logic             period_wr;
  logic             blink_phase;
  logic             tick;
  logic [WIDTH-1:0] next_out;

  assign wr_en     = chipselect & ~write_n;
  assign wd_w      = writedata[WIDTH-1:0];
  assign period_wr = wr_en && (address == ADDR_BLINK_PERIOD);

  // Register file; SET/CLEAR/TOGGLE use only the low WIDTH data bits and
  // PWM duty is stored already clamped to full-on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= PER_W'(1);
      duty_q     <= DUTY_FULL;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:         data_q     <= wd_w;
        ADDR_SET:          data_q     <= data_q | wd_w;
        ADDR_CLEAR:        data_q     <= data_q & ~wd_w;
        ADDR_TOGGLE:       data_q     <= data_q ^ wd_w;
        ADDR_BLINK_EN:     blink_en_q <= wd_w;
        ADDR_BLINK_PERIOD: period_q   <= writedata[PER_W-1:0];
        ADDR_PWM_DUTY: begin
          if (writedata > DUTY_FULL_32) begin
            duty_q <= DUTY_FULL;
          end else begin
            duty_q <= writedata[PWM_W:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running PWM counter, wraps naturally at 2^PWM_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  assign pwm_on = ({1'b0, pwm_cnt} < duty_q);

  platform_led_blink_timer #(
    .PRESCALE (PRESCALE),
    .PER_W    (PER_W)
  ) u_blink_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .period      (period_q),
    .period_wr   (period_wr),
    .blink_phase (blink_phase),
    .tick        (tick)
  );

  // Per-channel gating: blinking channels follow the phase, all follow PWM.
  always_comb begin
    next_out = data_q & (~blink_en_q | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
  end

  // Registered LED drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= next_out;
    end
  end

  // Read mux; SET/CLEAR/TOGGLE addresses read back DATA.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: readdata = 32'(data_q);
      ADDR_BLINK_EN:     readdata = 32'(blink_en_q);
      ADDR_BLINK_PERIOD: readdata = 32'(period_q);
      ADDR_PWM_DUTY:     readdata = 32'(duty_q);
      default: begin
        readdata[STATUS_BLINK_PHASE] = blink_phase;
        readdata[STATUS_PWM_ON]      = pwm_on;
      end
    endcase
  end

endmodule

// File: tb/tb_platform_led_ctrl.sv
// Bench for platform_led_ctrl (WIDTH=10, PRESCALE=4, PWM_W=4,
// RESET_VALUE=0x155): directed scenarios with literal expectations plus
// randomized bus traffic, all checked every cycle against a behavioural
// model built from cycle counts and tick counts.
module tb_platform_led_ctrl;

  localparam int              WIDTH    = 10;
  localparam int              PRESCALE = 4;
  localparam int              PER_W    = 16;
  localparam int              PWM_W    = 4;
  localparam logic [WIDTH-1:0] RV      = 10'h155;
  localparam int              PWM_PER  = 1 << PWM_W;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  platform_led_ctrl #(
    .WIDTH       (WIDTH),
    .PRESCALE    (PRESCALE),
    .PER_W       (PER_W),
    .PWM_W       (PWM_W),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Counters are expressed as "edges since reset" and "ticks since the
  // last period write"; the phase is derived by division.
  logic [WIDTH-1:0] m_data, m_en, m_out;
  logic [PER_W-1:0] m_per;
  int               m_duty;
  int               m_cyc;
  int               m_ticks;

  function automatic bit m_phase();
    if (m_per == 0) return 1'b1;
    return ((m_ticks / int'(m_per)) % 2) == 0;
  endfunction

  function automatic bit m_pwm_on();
    return (m_cyc % PWM_PER) < m_duty;
  endfunction

  function automatic bit m_tick();
    return (m_cyc % PRESCALE) == PRESCALE - 1;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_data);
      3'd4:    return 32'(m_en);
      3'd5:    return 32'(m_per);
      3'd6:    return 32'(m_duty);
      default: return {30'd0, m_pwm_on(), m_phase()};
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] m_next_out();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = m_data[i] && (m_en[i] ? m_phase() : 1'b1) && m_pwm_on();
    end
    return r;
  endfunction

  // Model state advance at each edge; reset is asynchronous as in the DUT.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  <= RV;
      m_en    <= '0;
      m_per   <= 16'd1;
      m_duty  <= PWM_PER;
      m_cyc   <= 0;
      m_ticks <= 0;
      m_out   <= RV;
    end else begin
      m_out <= m_next_out();
      m_cyc <= m_cyc + 1;
      if (chipselect && !write_n && address == 3'd5) m_ticks <= 0;
      else if (m_tick() && m_per != 0) m_ticks <= m_ticks + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[WIDTH-1:0];
          3'd1: m_data <= m_data | writedata[WIDTH-1:0];
          3'd2: m_data <= m_data & ~writedata[WIDTH-1:0];
          3'd3: m_data <= m_data ^ writedata[WIDTH-1:0];
          3'd4: m_en   <= writedata[WIDTH-1:0];
          3'd5: m_per  <= writedata[PER_W-1:0];
          3'd6: m_duty <= (writedata > 32'(PWM_PER)) ? PWM_PER : int'(writedata);
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Every cycle, mid-period: DUT outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("out_port_model", 32'(out_port), 32'(m_out));
      chk("readdata_model", readdata, m_rd(address));
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] expv);
    address = a;
    #1;
    chk(name, readdata, expv);
  endtask

  // Edges between two consecutive changes of out_port[0]; 999 on timeout.
  task automatic measure_toggle(output int period);
    logic prev;
    int   k;
    period = 999;
    prev = out_port[0];
    k = 0;
    while (out_port[0] == prev && k < 60) begin idle(1); k++; end
    if (k < 60) begin
      prev = out_port[0];
      k = 0;
      while (out_port[0] == prev && k < 60) begin idle(1); k++; end
      if (k < 60) period = k;
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    for (int i = 0; i < PWM_PER; i++) begin
      idle(1);
      if (out_port[0]) n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int per, n, k;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    reset_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    started = 1'b1;

    // Reset + static
    chk("reset_out_port", 32'(out_port), 32'h155);
    rd_chk("reset_blink_period", 3'd5, 32'd1);
    rd_chk("reset_pwm_duty", 3'd6, 32'd16);
    wr(3'd0, 32'h3FF);
    chk("data_write_edge_n", 32'(out_port), 32'h155);
    idle(1);
    chk("data_write_edge_n1", 32'(out_port), 32'h3FF);

    // Atomic operations
    wr(3'd0, 32'h0F0);
    wr(3'd1, 32'h003);
    rd_chk("set", 3'd0, 32'h0F3);
    wr(3'd2, 32'h030);
    rd_chk("clear", 3'd0, 32'h0C3);
    wr(3'd3, 32'hFFFF_FE01);
    rd_chk("toggle_upper_ignored", 3'd3, 32'h2C2);

    // Blink with period 3: half-period 12 cycles
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h001);
    wr(3'd5, 32'd3);
    measure_toggle(per);
    chk("blink_half_period", 32'(per), 32'd12);
    chk("blink_other_bits", 32'(out_port[9:1]), 32'h1FF);
    wr(3'd5, 32'd0);
    idle(30);
    chk("period0_bit0", 32'(out_port[0]), 32'd1);
    rd_chk("period0_status", 3'd7, 32'h3);

    // Period rewrite coincident with a tick
    k = 0;
    while ((m_cyc % PRESCALE) != PRESCALE - 1 && k < 8) begin idle(1); k++; end
    wr(3'd5, 32'd2);
    rd_chk("coincident_phase", 3'd7, 32'h3);
    k = 0;
    while (readdata[0] == 1'b1 && k < 40) begin idle(1); k++; end
    chk("coincident_next_toggle", 32'(k), 32'd8);

    // PWM brightness
    wr(3'd4, 32'h000);
    wr(3'd0, 32'h001);
    wr(3'd6, 32'd4);
    idle(2);
    count_high(n);
    chk("pwm_duty4", 32'(n), 32'd4);
    wr(3'd6, 32'd0);
    idle(2);
    count_high(n);
    chk("pwm_duty0", 32'(n), 32'd0);
    wr(3'd6, 32'hFF);
    rd_chk("pwm_clamp_read", 3'd6, 32'd16);
    idle(2);
    count_high(n);
    chk("pwm_full", 32'(n), 32'd16);

    // Asynchronous reset mid-blink
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h3FF);
    wr(3'd5, 32'd1);
    idle(9);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_port", 32'(out_port), 32'h155);
    rd_chk("async_data", 3'd0, 32'h155);
    rd_chk("async_blink_en", 3'd4, 32'd0);
    idle(1);
    reset_n = 1'b1;
    rd_chk("post_reset_phase", 3'd7, 32'h3);
    wr(3'd4, 32'h3FF);
    idle(2);
    chk("post_reset_blink_on", 32'(out_port), 32'h155);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      case (address)
        3'd5:    writedata = $urandom_range(0, 4);
        3'd6:    writedata = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 20);
        default: writedata = $urandom;
      endcase
      idle(1);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/platform_led_ctrl.md
Name: platform_led_ctrl

Overview:
- Parametrised successor to the platform's single-register Avalon-MM LED output port.
- Adds the following, all on one zero-wait-state Avalon-MM slave:
  - atomic SET/CLEAR/TOGGLE writes;
  - per-channel blink enable with a programmable blink period;
  - global PWM brightness.
- Sits on the Qsys interconnect and drives board LEDs directly.

Parameters:
- WIDTH, 10, number of LED channels (1..32).
- PRESCALE, 50000, clk cycles per blink tick (>=1).
- PER_W, 16, width of the BLINK_PERIOD register (1..32).
- PWM_W, 8, PWM counter width (1..16).
- RESET_VALUE, 0, reset value of DATA (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- out_port  out  WIDTH  LED drive; registered.

Behaviour:
- Write occurs when chipselect=1 and write_n=0. The target register updates on that clk edge. Writes to address 7 are ignored.
- Register map:
  - 0 DATA: R/W, bits [WIDTH-1:0].
  - 1 SET: DATA |= wd.
  - 2 CLEAR: DATA &= ~wd.
  - 3 TOGGLE: DATA ^= wd.
  - 4 BLINK_EN: R/W, WIDTH bits.
  - 5 BLINK_PERIOD: R/W, PER_W bits.
  - 6 PWM_DUTY: R/W, PWM_W+1 bits.
  - 7 STATUS: RO; bit0 = blink_phase, bit1 = pwm_on.
- readdata:
  - Addresses 1..3 read back DATA.
  - Unused upper bits read 0.
  - Reads have no side effects.
  - The read mux is driven regardless of chipselect.
- Reset values:
  - DATA=RESET_VALUE, BLINK_EN=0, BLINK_PERIOD=1, PWM_DUTY=2^PWM_W (full on).
  - blink_phase=1; all counters 0.
  - out_port=RESET_VALUE masked by full-on PWM, i.e. RESET_VALUE.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps.
  - `tick` pulses for 1 cycle on the wrap.
- Blink counter:
  - On tick, if BLINK_PERIOD != 0: when blink_cnt == BLINK_PERIOD-1, toggle blink_phase and set blink_cnt to 0; otherwise increment blink_cnt.
  - Phase half-period = BLINK_PERIOD*PRESCALE cycles.
  - BLINK_PERIOD=0: counter frozen, blink_phase forced to 1, so blinking channels appear solid on.
  - A write to BLINK_PERIOD resets blink_cnt=0 and blink_phase=1 on the same edge. This write wins over a coincident tick.
  - The prescaler is not affected by register writes.
- PWM:
  - pwm_cnt is a free-running PWM_W-bit counter that increments every clk and wraps at 2^PWM_W-1 -> 0.
  - pwm_on = (pwm_cnt < duty_eff), where duty_eff = min(PWM_DUTY, 2^PWM_W).
  - Duty 0 gives always off; 2^PWM_W or greater gives always on.
  - PWM_DUTY write data above 2^PWM_W is stored clamped to 2^PWM_W.
- Output equation, per bit i:
  - next_out[i] = DATA[i] & (BLINK_EN[i] ? blink_phase : 1) & pwm_on.
  - out_port <= next_out on every clk edge.
  - Latency: a write at edge N changes a register at N; out_port reflects it at edge N+1.
- Only one address per cycle, so register writes never conflict.
- SET/CLEAR/TOGGLE bits above WIDTH are ignored.
- reset_n assertion mid-operation immediately returns every register, counter and out_port to its reset value, with no clock needed.

Decomposition:
- Shared package platform_led_pkg holds:
  - address constants ADDR_DATA..ADDR_STATUS (3-bit);
  - STATUS bit indices.
- One sub-module, platform_led_blink_timer, contains:
  - the prescaler and blink counter;
  - inputs: period, period_wr;
  - outputs: blink_phase, tick.
- PWM counter, registers and read mux stay in the top level.

Test Plan:
- Reset + static (WIDTH=10, RESET_VALUE=0x155): after reset out_port=0x155 and rd(5)=1. Write 0x3FF to addr 0 at edge N -> out_port=0x3FF at edge N+1.
- Atomic ops, starting from DATA=0x0F0:
  - SET 0x003 -> rd(0)=0x0F3;
  - CLEAR 0x030 -> 0x0C3;
  - TOGGLE 0x201 -> 0x2C2;
  - writedata bits above 9 are ignored.
- Blink (PRESCALE=4, DATA=0x3FF, BLINK_EN=0x001, BLINK_PERIOD=3): bit0 toggles every 12 cycles and bits 9:1 stay 1. BLINK_PERIOD=0 -> bit0 held at 1 and STATUS bit0=1.
- Period rewrite coincident with tick (PRESCALE=4): write BLINK_PERIOD=2 in the same cycle as a tick -> phase=1, and the next toggle occurs 8 cycles later.
- PWM (PWM_W=4, DATA=0x001):
  - duty 4 -> out_port[0] high 4 of every 16 cycles;
  - duty 0 -> always 0;
  - writing 0xFF -> rd(6)=16 and output always 1.
- Async reset mid-blink: assert reset_n low between clk edges -> out_port, DATA and counters return to reset values immediately. Deassert -> blink restarts with phase=1.
